// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers
//   clk, rst          : system clock, synchronous active-high reset
//   req_valid/req_data: per-requester byte offer, byte k at [8k+7:8k]
//   req_ready         : one-hot accept pulse, coincident with tx_start
//   tx_data/tx_start  : byte and one-cycle launch pulse to the transmitter
//   clear_req         : end-of-frame pulse from the transmitter
//   timeout_cycles    : watchdog limit in cycles, 0 disables it
//   busy/grant_id     : frame outstanding / last granted requester
//   timeout_err       : one-cycle pulse when the watchdog abandons a frame
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   clear_req,
    input  logic [31:0]            timeout_cycles,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   timeout_err
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [7:0]         data_q, data_d;
    logic               start_q, start_d, busy_q, busy_d, terr_q, terr_d;
    logic [ID_W-1:0]    grant_q, grant_d, sel, idx;
    logic               found;
    // first valid requester after the last grant, wrapping modulo NUM_REQ
    always_comb begin
        sel = grant_q;
        idx = grant_q;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && req_valid[idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        ready_d = '0;
        data_d  = data_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        grant_d = grant_q;
        terr_d  = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (found) begin
                ready_d[sel] = 1'b1;
                data_d  = req_data[{sel, 3'b000} +: 8];
                start_d = 1'b1;
                grant_d = sel;
                busy_d  = 1'b1;
                state_d = BUSY;
            end
        end else if (clear_req && !start_q) begin
            // a pulse in the launch cycle belongs to an earlier frame
            busy_d  = 1'b0;
            state_d = IDLE;
        end else if (timeout_cycles != '0 && cnt_q == timeout_cycles - 32'd1) begin
            terr_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= ID_W'(NUM_REQ - 1);
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            terr_q  <= terr_d;
        end
    end
    assign req_ready   = ready_q;
    assign tx_data     = data_q;
    assign tx_start    = start_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a behavioural model
module tb_uart_tx_arbiter;
    localparam int N  = 3;
    localparam int IW = 2;
    logic           clk = 1'b0, rst = 1'b1, clear_req = 1'b0;
    logic [N-1:0]   req_valid = '0, req_ready;
    logic [8*N-1:0] req_data = '0;
    logic [7:0]     tx_data;
    logic           tx_start, busy, timeout_err;
    logic [IW-1:0]  grant_id;
    logic [31:0]    timeout_cycles = '0;
    int             total = 0, bad = 0, cyc = 0, stub = 0;
    bit             chk_en = 1'b0;
    logic [N-1:0]   e_ready;
    logic [7:0]     e_data;
    logic           e_start, e_busy, e_terr;
    int             e_grant = 0, e_start_cyc = 0, nxt;

    uart_tx_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
        .clear_req(clear_req), .timeout_cycles(timeout_cycles), .busy(busy),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // next requester in round-robin order after 'last', or -1 if nobody is asking
    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++)
            if (v[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    always_comb nxt = pick(req_valid, e_grant);

    // model: a frame is outstanding from its launch cycle until a clear_req after
    // launch, or until timeout_cycles cycles have elapsed since launch
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        e_ready <= '0;
        e_start <= 1'b0;
        e_terr  <= 1'b0;
        if (rst) begin
            e_data  <= '0;
            e_busy  <= 1'b0;
            e_grant <= N - 1;
        end else if (!e_busy) begin
            if (nxt >= 0) begin
                e_ready     <= N'(1) << nxt;
                e_data      <= 8'(req_data >> (8 * nxt));
                e_start     <= 1'b1;
                e_busy      <= 1'b1;
                e_grant     <= nxt;
                e_start_cyc <= cyc + 1;
            end
        end else if (clear_req && cyc != e_start_cyc) begin
            e_busy <= 1'b0;
        end else if (timeout_cycles != 0 && cyc + 1 - e_start_cyc == timeout_cycles) begin
            e_terr <= 1'b1;
            e_busy <= 1'b0;
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("tx_data", 32'(tx_data), 32'(e_data));
        chk("tx_start", 32'(tx_start), 32'(e_start));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("grant_id", 32'(grant_id), e_grant);
        chk("timeout_err", 32'(timeout_err), 32'(e_terr));
    end

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 50);
        chk("start_seen", 32'(tx_start), 1);
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 2);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst = 1'b0;
        // contention: two requesters held valid alternate
        req_data = {8'h00, 8'h0f, 8'h41};
        req_valid = 3'b011;
        for (int g = 0; g < 4; g++) begin
            wait_start(n);
            if (g > 0) chk("cont_gap", n, 1);
            chk("cont_grant", 32'(grant_id), g % 2);
            chk("cont_data", 32'(tx_data), (g % 2) ? 32'h0f : 32'h41);
            if (g == 3) req_valid = '0;
            repeat (3) @(negedge clk);
            pulse_clear();
        end
        chk("cont_idle", 32'(busy), 0);
        // single byte
        req_data[7:0] = 8'h41;
        req_valid = 3'b001;
        wait_start(n);
        chk("single_ready", 32'(req_ready), 1);
        chk("single_data", 32'(tx_data), 32'h41);
        chk("single_busy", 32'(busy), 1);
        req_valid = '0;
        repeat (5) @(negedge clk);
        chk("single_hold", 32'(busy), 1);
        pulse_clear();
        chk("single_fall", 32'(busy), 0);
        repeat (4) @(negedge clk);
        chk("single_no_regrant", 32'(busy), 0);
        // stale clear_req in idle and in the launch cycle
        pulse_clear();
        @(negedge clk);
        req_data[15:8] = 8'hA5;
        req_valid = 3'b010;
        wait_start(n);
        chk("stale_grant", 32'(grant_id), 1);
        chk("stale_data", 32'(tx_data), 32'hA5);
        pulse_clear();
        req_valid = '0;
        chk("stale_hold", 32'(busy), 1);
        repeat (10) @(negedge clk);
        chk("stale_hold2", 32'(busy), 1);
        pulse_clear();
        chk("stale_fall", 32'(busy), 0);
        // watchdog
        timeout_cycles = 20;
        req_data[7:0] = 8'h33;
        req_valid = 3'b001;
        wait_start(n);
        chk("wd_grant", 32'(grant_id), 0);
        req_valid = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 100);
        chk("wd_delay", n, 20);
        chk("wd_busy", 32'(busy), 0);
        @(negedge clk);
        chk("wd_once", 32'(timeout_err), 0);
        req_data[23:16] = 8'h5a;
        req_valid = 3'b100;
        wait_start(n);
        chk("wd_next_grant", 32'(grant_id), 2);
        req_valid = '0;
        @(negedge clk);
        pulse_clear();
        // watchdog disabled
        timeout_cycles = 0;
        req_valid = 3'b010;
        wait_start(n);
        req_valid = '0;
        repeat (100) @(negedge clk);
        chk("wd_off_busy", 32'(busy), 1);
        pulse_clear();
        // reset mid-frame
        req_valid = 3'b001;
        wait_start(n);
        chk("pre_rst_grant", 32'(grant_id), 0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        req_valid = 3'b011;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_grant", 32'(grant_id), 2);
        chk("mid_rst_data", 32'(tx_data), 0);
        wait_start(n);
        chk("post_rst_grant", 32'(grant_id), 0);
        req_valid = '0;
        @(negedge clk);
        pulse_clear();
        // clear_req coinciding with the watchdog limit
        timeout_cycles = 10;
        req_valid = 3'b100;
        wait_start(n);
        req_valid = '0;
        repeat (9) @(negedge clk);
        pulse_clear();
        chk("tie_terr", 32'(timeout_err), 0);
        chk("tie_busy", 32'(busy), 0);
        // randomized traffic with a stub transmitter
        stub = 0;
        for (int seg = 0; seg < 6; seg++) begin
            timeout_cycles = (seg % 3 == 0) ? 32'd0 : 32'($urandom_range(1, 40));
            if (timeout_cycles == 0 && stub < 0) stub = 3;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                clear_req = 1'b0;
                if (tx_start) begin
                    stub = (timeout_cycles != 0 && $urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 30));
                    if ($urandom_range(0, 9) == 0) clear_req = 1'b1;
                end else if (stub > 0) begin
                    stub--;
                    if (stub == 0) clear_req = 1'b1;
                end else if (stub == 0 && $urandom_range(0, 39) == 0) begin
                    clear_req = 1'b1;
                end
                if (!busy && !tx_start && stub < 0) stub = 0;
                for (int k = 0; k < N; k++) begin
                    if (req_ready[k]) begin
                        req_valid[k] = 1'($urandom_range(0, 1));
                        req_data[8*k +: 8] = 8'($urandom);
                    end else if (!req_valid[k]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            req_valid[k] = 1'b1;
                            req_data[8*k +: 8] = 8'($urandom);
                        end
                    end else if ($urandom_range(0, 49) == 0) begin
                        req_valid[k] = 1'b0;
                    end
                end
                rst = ($urandom_range(0, 299) == 0);
            end
        end
        rst = 1'b0;
        clear_req = 1'b0;
        req_valid = '0;
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_transmission instance between NUM_REQ byte producers, such as the Wishbone CSR path and a debug/log source. Each requester offers bytes over a valid/ready handshake. The arbiter grants one requester, launches that byte into the transmitter with a one-cycle tx_start, then waits for clear_req before granting again. A watchdog recovers the arbiter if clear_req never arrives.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, width of grant_id; must equal clog2(NUM_REQ), minimum 1

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
req_valid  input  NUM_REQ  bit k: requester k holds a byte
req_data  input  8*NUM_REQ  byte k is at [8k+7:8k]; stable while req_valid[k] is high
req_ready  output  NUM_REQ  one-hot, one-cycle pulse: byte k accepted this cycle
tx_data  output  8  byte to uart_transmission.tx_data
tx_start  output  1  one-cycle launch pulse to uart_transmission.tx_start
clear_req  input  1  from uart_transmission; one-cycle pulse at end of frame (stop bit done)
timeout_cycles  input  32  watchdog limit in clk cycles; 0 disables the watchdog
busy  output  1  high while a granted frame is outstanding
grant_id  output  ID_W  index of the last granted requester
timeout_err  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset values: req_ready=0, tx_data=8'h00, tx_start=0, busy=0, grant_id=NUM_REQ-1, timeout_err=0, state=IDLE, watchdog counter=0. Because grant_id resets to NUM_REQ-1, requester 0 has first priority.
- All outputs are registered.
- State IDLE:
  - If any req_valid bit is high in cycle t, select the first valid index searching from grant_id+1 upward, wrapping modulo NUM_REQ.
  - In cycle t+1: req_ready[k]=1, tx_data=req_data[k], tx_start=1, grant_id=k, busy=1, state=BUSY, counter=0.
  - If no req_valid bit is high, stay in IDLE with all pulses low.
- State BUSY:
  - req_ready=0 and tx_start=0; tx_data holds its value.
  - The counter increments every cycle.
  - On clear_req=1: busy=0 and state=IDLE in the next cycle. The earliest next grant is one cycle after that, so there is a minimum 2-cycle gap between a clear_req pulse and the next tx_start.
  - Watchdog: if timeout_cycles!=0 and the counter reaches timeout_cycles-1 without clear_req, then in the next cycle timeout_err=1 for one cycle, busy=0, state=IDLE. The byte is considered lost and is not retried.
  - If clear_req arrives in the same cycle the counter hits the limit, clear_req wins: no timeout_err.
- clear_req is ignored in IDLE and in the tx_start cycle itself. A stale pulse must not release a grant.
- Fairness: a requester that holds req_valid continuously is served within NUM_REQ grants. A requester that deasserts req_valid before its grant loses its turn; no state is held for it.
- Handshake: a transfer occurs only when req_valid[k]&req_ready[k]. The requester may change req_data or drop req_valid in the cycle after req_ready.
- Reset mid-frame: returns to IDLE with reset values and drops the grant. The transmitter is reset by the same rst.
- tx_data is sampled only at grant. Later changes on req_data do not affect the frame in flight.

Test Plan:
- Single byte: with clk_div=8, set req_valid[0]=1 and req_data[7:0]=8'h41. Expect req_ready[0] and tx_start to pulse together in the same cycle with tx_data=8'h41 and busy=1, tx to carry the 0x41 frame, busy to fall one cycle after clear_req, and no second grant while req_valid[0] is dropped.
- Contention: hold req_valid=2'b11 with bytes 8'h41 (req 0) and 8'h0f (req 1) across four grants. Expect grant order 0,1,0,1 and tx frames 41,0f,41,0f, with each tx_start at least 2 cycles after the preceding clear_req.
- Stale clear_req: in IDLE, inject a clear_req pulse, then request req 1 with 8'hA5. Expect a normal grant, and busy to stay high until the genuine end-of-frame clear_req.
- Watchdog: set timeout_cycles=20 and tie clear_req low in a stub transmitter, then issue a request. Expect timeout_err to pulse exactly once 20 cycles after tx_start, busy=0, and the next grant to proceed. With timeout_cycles=0, busy must stay high indefinitely.
- Reset mid-frame: assert rst for one cycle 30 cycles into a frame. Expect all outputs at reset values on the next edge, and the next grant to go to requester 0 even if grant_id was 0 before reset.
- Clear/timeout tie: set timeout_cycles so the limit coincides with the clear_req cycle. Expect no timeout_err and a normal return to IDLE.
